// File: rtl/op2_loader.sv
// op2_loader: serial-to-parallel front end for the 32-input second-stage adder.
// Collects 32 unsigned 9-bit words over a valid/ready stream. Presents them as
// one 288-bit frame together with the adder-equivalent reduction sum[11:3].

module op2_loader (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [8:0]   in_data,
  output logic         in_ready,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [287:0] data_out,
  output logic [8:0]   sum_out
);

  // Two-state handshake controller: filling the frame, or holding it for the consumer.
  localparam logic FILL = 1'b0;
  localparam logic HOLD = 1'b1;

  logic        state_r;
  logic [4:0]  count_r;
  logic [13:0] acc_r;

  logic        accept_s;
  logic        handoff_s;
  logic        last_s;
  logic [13:0] acc_next_s;

  // Handshake outputs depend only on the state register, so no input-to-output
  // combinational path exists between the two streams.
  assign in_ready  = (state_r == FILL);
  assign out_valid = (state_r == HOLD);

  // Transfer qualifiers and the running-sum update.
  always_comb begin
    accept_s   = in_valid && in_ready;
    handoff_s  = out_valid && out_ready;
    last_s     = accept_s && (count_r == 5'd31);
    acc_next_s = acc_r + {5'd0, in_data};
  end

  // State transitions: FILL -> HOLD on the 32nd word, HOLD -> FILL on handoff.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= FILL;
    end else begin
      case (state_r)
        FILL: begin
          if (last_s) begin
            state_r <= HOLD;
          end else begin
            state_r <= FILL;
          end
        end
        HOLD: begin
          if (handoff_s) begin
            state_r <= FILL;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r <= FILL;
        end
      endcase
    end
  end

  // Word counter: advances per accepted word. It wraps to 0 after slot 31.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= 5'd0;
    end else if (accept_s) begin
      count_r <= count_r + 5'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // Running serial sum. It restarts from zero once a frame completes.
  // The 14-bit width covers 32*511, so this cannot overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_r <= 14'd0;
    end else if (last_s) begin
      acc_r <= 14'd0;
    end else if (accept_s) begin
      acc_r <= acc_next_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  // Reduced sum: updated only on frame completion, and it drops the same bits
  // that the adder stage truncates.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_out <= 9'd0;
    end else if (last_s) begin
      sum_out <= acc_next_s[11:3];
    end else begin
      sum_out <= sum_out;
    end
  end

  // Frame word registers: each slot is overwritten when it refills. Slots are
  // never cleared between frames, so stale words are valid only under out_valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out <= 288'd0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (accept_s && (count_r == 5'(i))) begin
          data_out[i*9 +: 9] <= in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_op2_loader.sv
// Directed self-checking bench for op2_loader.

module tb_op2_loader;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic [8:0]   in_data;
  logic         in_ready;
  logic         out_ready;
  logic         out_valid;
  logic [287:0] data_out;
  logic [8:0]   sum_out;

  int errors;
  int checks;

  logic [8:0]   words [32];
  logic [287:0] exp_data;
  logic [8:0]   exp_sum;
  int           waited;

  op2_loader dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .data_out (data_out),
    .sum_out  (sum_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: pack the words, with word 0 in the low bits.
  function automatic logic [287:0] model_pack();
    logic [287:0] v;
    v = 288'd0;
    for (int i = 0; i < 32; i++) v[i*9 +: 9] = words[i];
    return v;
  endfunction

  // Reference model: 14-bit sum of the frame, with bits [11:3] kept.
  function automatic logic [8:0] model_sum();
    logic [13:0] s;
    s = 14'd0;
    for (int i = 0; i < 32; i++) s = s + {5'd0, words[i]};
    return s[11:3];
  endfunction

  // Offer one word after 'gap' idle cycles and wait until it is accepted.
  // On return the time is #1 after the accepting edge.
  task automatic push(input logic [8:0] d, input int gap, output int w);
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      in_data = 9'($urandom_range(0, 511));
      @(posedge clock); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clock); #1;
      w++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_timeout: in_ready=%b after %0d cycles, required 1", in_ready, w);
    end else begin
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 9'd0; out_ready = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    checks++;
    if (data_out !== 288'd0 || sum_out !== 9'd0) begin
      errors++;
      $display("FAIL reset_data: data_out=%h sum_out=%h, required 0/0", data_out, sum_out);
    end
    #5 reset = 1'b0;   // release mid-cycle
    @(posedge clock); #1;
  endtask

  task automatic test_ramp();
    out_ready = 1'b1;
    for (int i = 0; i < 31; i++) push(9'(i), 0, waited);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ramp_early: out_valid=%b in_ready=%b after 31 words, required 0/1", out_valid, in_ready);
    end
    push(9'd31, 0, waited);
    for (int i = 0; i < 32; i++) words[i] = 9'(i);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ramp_latency: out_valid=%b in_ready=%b, required 1/0", out_valid, in_ready);
    end
    checks++;
    if (data_out !== model_pack()) begin
      errors++;
      $display("FAIL ramp_data: got %h required %h", data_out, model_pack());
    end
    checks++;
    if (sum_out !== 9'd62) begin
      errors++;
      $display("FAIL ramp_sum: got %0d required 62", sum_out);
    end
    @(posedge clock); #1;   // handoff edge
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ramp_handoff: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_max();
    for (int i = 0; i < 32; i++) begin
      push(9'h1FF, 0, waited);
      if (i == 0) begin
        checks++;
        if (waited != 0) begin
          errors++;
          $display("FAIL max_first_accept: waited %0d cycles, required 0", waited);
        end
      end
    end
    checks++;
    if (sum_out !== 9'h1FC) begin
      errors++;
      $display("FAIL max_sum: got %h required 1fc", sum_out);
    end
    checks++;
    if (data_out !== {288{1'b1}}) begin
      errors++;
      $display("FAIL max_data: got %h required all ones", data_out);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL max_handoff: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      words[i] = 9'((i * 7 + 3) % 512);
      push(words[i], 0, waited);
    end
    exp_data = model_pack();
    exp_sum  = model_sum();
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_data  = 9'(c * 37 + 5);
      @(posedge clock); #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_handshake: cycle %0d in_ready=%b out_valid=%b, required 0/1", c, in_ready, out_valid);
      end
      checks++;
      if (data_out !== exp_data || sum_out !== exp_sum) begin
        errors++;
        $display("FAIL bp_stable: cycle %0d sum=%h required %h data=%h", c, sum_out, exp_sum, data_out);
      end
    end
    in_data   = 9'h0AB;
    out_ready = 1'b1;
    @(posedge clock); #1;   // handoff edge; in_valid stays high
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    @(posedge clock); #1;   // accepts 0x0AB as word 0
    in_valid = 1'b0;
    words[0] = 9'h0AB;
    for (int i = 1; i < 32; i++) begin
      words[i] = 9'(500 - i * 3);
      push(words[i], 0, waited);
    end
    checks++;
    if (data_out[8:0] !== 9'h0AB) begin
      errors++;
      $display("FAIL bp_word0: got %h required 0ab", data_out[8:0]);
    end
    checks++;
    if (data_out !== model_pack() || sum_out !== model_sum()) begin
      errors++;
      $display("FAIL bp_next_frame: sum=%h required %h", sum_out, model_sum());
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_bubbles();
    for (int f = 0; f < 100; f++) begin
      for (int i = 0; i < 32; i++) words[i] = 9'($urandom_range(0, 511));
      for (int i = 0; i < 32; i++) begin
        out_ready = 1'($urandom_range(0, 1));
        push(words[i], $urandom_range(0, 5), waited);
      end
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bubbles_valid: frame %0d out_valid=%b required 1", f, out_valid);
      end
      checks++;
      if (data_out !== model_pack() || sum_out !== model_sum()) begin
        errors++;
        $display("FAIL bubbles_frame: frame %0d sum=%h required %h data=%h", f, sum_out, model_sum(), data_out);
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 17; i++) push(9'h155, 0, waited);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (data_out !== 288'd0 || sum_out !== 9'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_outputs: data=%h sum=%h out_valid=%b in_ready=%b, required 0/0/0/1", data_out, sum_out, out_valid, in_ready);
    end
    #10 reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      words[i] = 9'd8;
      push(9'd8, 0, waited);
    end
    checks++;
    if (sum_out !== 9'd32) begin
      errors++;
      $display("FAIL rst_mid_sum: got %0d required 32", sum_out);
    end
    checks++;
    if (data_out !== model_pack()) begin
      errors++;
      $display("FAIL rst_mid_data: got %h required %h", data_out, model_pack());
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_hold();
    for (int i = 0; i < 32; i++) push(9'(i + 100), 0, waited);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_hold_pre: out_valid=%b required 1", out_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || data_out !== 288'd0 || sum_out !== 9'd0) begin
      errors++;
      $display("FAIL rst_hold_async: out_valid=%b sum=%h data=%h, required 0/0/0", out_valid, sum_out, data_out);
    end
    #10 reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    for (int i = 0; i < 32; i++) begin
      words[i] = 9'd1;
      push(9'd1, 0, waited);
    end
    checks++;
    if (sum_out !== 9'd4 || data_out !== model_pack()) begin
      errors++;
      $display("FAIL rst_hold_next: sum=%0d required 4 data=%h", sum_out, data_out);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_ramp();
    test_max();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_reset_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
